// File: rtl/xadc_stream_arbiter_if.sv
// 16-bit AXI-Stream bundle shared by the XADC sample streams and the merged output.
// Source drives the payload and sideband, Sink drives tready.
interface axis_interface #(
    parameter int DATA_W = 16
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic [DATA_W/8-1:0] tkeep;
    logic              tid;
    logic              tdest;
    logic              tuser;

    modport Source (output tvalid, tdata, tlast, tkeep, tid, tdest, tuser, input tready);
    modport Sink   (input tvalid, tdata, tlast, tkeep, tid, tdest, tuser, output tready);
    modport master (output tvalid, tdata, tlast, tkeep, tid, tdest, tuser, input tready);
    modport slave  (input tvalid, tdata, tlast, tkeep, tid, tdest, tuser, output tready);
endinterface

// File: rtl/xadc_stream_arbiter.sv
// Round-robin merge of the voltage and current XADC streams onto one tagged,
// framed 16-bit AXIS output with a single registered output stage.
module xadc_stream_arbiter #(
    parameter int FRAME_LEN = 64,
    localparam int CNT_W = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    axis_interface.Sink      voltage_channel,
    axis_interface.Sink      current_monitor_channel,
    axis_interface.Source    out_axis,
    output logic             last_grant,
    output logic [CNT_W-1:0] word_cnt_o
);
    // Handshake: a word moves on any interface in a cycle where tvalid && tready
    // are both high at the rising clk edge; tvalid never waits on tready.

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_LEN - 1);
    localparam logic [3:0]       TAG_V   = 4'h1;
    localparam logic [3:0]       TAG_C   = 4'h2;

    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    logic load;
    logic any_req;
    logic grant_cur;
    logic fire;

    always_comb begin
        load    = !rst && enable && (!out_valid_q || out_axis.tready);
        any_req = voltage_channel.tvalid || current_monitor_channel.tvalid;
        // On a tie the channel that did not win last time goes next.
        if (voltage_channel.tvalid && current_monitor_channel.tvalid) begin
            grant_cur = !last_grant_q;
        end else begin
            grant_cur = current_monitor_channel.tvalid;
        end
        fire = load && any_req;
    end

    assign voltage_channel.tready         = load && voltage_channel.tvalid && !grant_cur;
    assign current_monitor_channel.tready = load && current_monitor_channel.tvalid && grant_cur;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        last_grant_d = last_grant_q;
        word_cnt_d   = word_cnt_q;
        if (fire) begin
            out_valid_d  = 1'b1;
            out_data_d   = grant_cur ? {current_monitor_channel.tdata[15:4], TAG_C}
                                     : {voltage_channel.tdata[15:4], TAG_V};
            out_last_d   = (word_cnt_q == CNT_MAX);
            last_grant_d = grant_cur;
            word_cnt_d   = (word_cnt_q == CNT_MAX) ? '0 : word_cnt_q + CNT_W'(1);
        end else if (out_valid_q && out_axis.tready) begin
            out_valid_d = 1'b0;
        end
        // Once disabled and drained, restart framing and give voltage the next tie.
        if (!enable && !out_valid_q) begin
            word_cnt_d   = '0;
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            last_grant_q <= 1'b1;
            word_cnt_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            last_grant_q <= last_grant_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    assign out_axis.tvalid = out_valid_q;
    assign out_axis.tdata  = out_data_q;
    assign out_axis.tlast  = out_last_q;
    assign out_axis.tkeep  = '1;
    assign out_axis.tid    = 1'b0;
    assign out_axis.tdest  = 1'b0;
    assign out_axis.tuser  = 1'b0;
    assign last_grant      = last_grant_q;
    assign word_cnt_o      = word_cnt_q;

    logic unused_inputs;
    assign unused_inputs = ^{voltage_channel.tdata[3:0], voltage_channel.tlast,
                             voltage_channel.tkeep, voltage_channel.tid,
                             voltage_channel.tdest, voltage_channel.tuser,
                             current_monitor_channel.tdata[3:0], current_monitor_channel.tlast,
                             current_monitor_channel.tkeep, current_monitor_channel.tid,
                             current_monitor_channel.tdest, current_monitor_channel.tuser};
endmodule

// File: tb/tb_xadc_stream_arbiter.sv
// Directed bench for xadc_stream_arbiter: a FRAME_LEN=64 instance for most scenarios
// and a FRAME_LEN=4 instance for the short-frame wrap.
module tb_xadc_stream_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       last_grant, last_grant4;
    logic [5:0] word_cnt;
    logic [1:0] word_cnt4;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [15:0] exp_q[$];

    axis_interface #(.DATA_W(16)) vin();
    axis_interface #(.DATA_W(16)) cin();
    axis_interface #(.DATA_W(16)) oax();
    axis_interface #(.DATA_W(16)) vin4();
    axis_interface #(.DATA_W(16)) cin4();
    axis_interface #(.DATA_W(16)) oax4();

    xadc_stream_arbiter #(.FRAME_LEN(64)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .voltage_channel(vin), .current_monitor_channel(cin), .out_axis(oax),
        .last_grant(last_grant), .word_cnt_o(word_cnt)
    );

    xadc_stream_arbiter #(.FRAME_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable),
        .voltage_channel(vin4), .current_monitor_channel(cin4), .out_axis(oax4),
        .last_grant(last_grant4), .word_cnt_o(word_cnt4)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        vin.tvalid = 0;  vin.tdata = '0;  cin.tvalid = 0;  cin.tdata = '0;  oax.tready = 0;
        vin4.tvalid = 0; vin4.tdata = '0; cin4.tvalid = 0; cin4.tdata = '0; oax4.tready = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        enable = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        enable = 1'b1;
        vin.tvalid = 1; cin.tvalid = 1; oax.tready = 1;
        vin4.tvalid = 1; oax4.tready = 1;
        #1 rst = 1'b1;
        tick();
        vec_cnt++;
        if ({oax.tvalid, oax.tdata, oax.tlast} !== 18'h0) begin
            err_cnt++; $display("FAIL reset_out got %h want %h", {oax.tvalid, oax.tdata, oax.tlast}, 18'h0);
        end
        vec_cnt++;
        if ({last_grant, word_cnt} !== {1'b1, 6'd0}) begin
            err_cnt++; $display("FAIL reset_state got %h want %h", {last_grant, word_cnt}, {1'b1, 6'd0});
        end
        vec_cnt++;
        if ({vin.tready, cin.tready, vin4.tready} !== 3'b000) begin
            err_cnt++; $display("FAIL reset_ready got %b want 000", {vin.tready, cin.tready, vin4.tready});
        end
        vec_cnt++;
        if ({oax.tkeep, oax.tid, oax.tdest, oax.tuser} !== 5'b11000) begin
            err_cnt++; $display("FAIL const_fields got %b want 11000", {oax.tkeep, oax.tid, oax.tdest, oax.tuser});
        end
        vec_cnt++;
        if ({oax4.tvalid, oax4.tlast, last_grant4, word_cnt4} !== 5'b00100) begin
            err_cnt++; $display("FAIL reset_dut4 got %b want 00100", {oax4.tvalid, oax4.tlast, last_grant4, word_cnt4});
        end
    endtask

    task automatic test_alternating();
        logic [17:0] exp;
        apply_reset();
        enable = 1'b1;
        vin.tdata = 16'hABC0; cin.tdata = 16'h1230;
        vin.tvalid = 1; cin.tvalid = 1; oax.tready = 1;
        #1;
        vec_cnt++;
        if ({vin.tready, cin.tready} !== 2'b10) begin
            err_cnt++; $display("FAIL first_grant got %b want 10", {vin.tready, cin.tready});
        end
        for (int i = 0; i < 130; i++) begin
            tick();
            exp = {1'b1, ((i % 2) == 0) ? 16'hABC1 : 16'h1232, (i % 64) == 63};
            vec_cnt++;
            if ({oax.tvalid, oax.tdata, oax.tlast} !== exp) begin
                err_cnt++; $display("FAIL alt_word%0d got %h want %h", i, {oax.tvalid, oax.tdata, oax.tlast}, exp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_single_requester();
        logic [11:0] s;
        apply_reset();
        enable = 1'b1;
        oax.tready = 1;
        cin.tvalid = 1;
        for (int k = 0; k < 10; k++) begin
            s = 12'h100 + 12'(k);
            cin.tdata = {s, 4'hF};
            #1;
            vec_cnt++;
            if ({vin.tready, cin.tready} !== 2'b01) begin
                err_cnt++; $display("FAIL single_ready%0d got %b want 01", k, {vin.tready, cin.tready});
            end
            tick();
            vec_cnt++;
            if ({oax.tvalid, oax.tdata, oax.tlast} !== {1'b1, s, 4'h2, 1'b0}) begin
                err_cnt++; $display("FAIL single_word%0d got %h want %h", k, {oax.tvalid, oax.tdata, oax.tlast}, {1'b1, s, 4'h2, 1'b0});
            end
        end
        cin.tvalid = 0;
        tick();
        vec_cnt++;
        if (oax.tvalid !== 1'b0) begin
            err_cnt++; $display("FAIL single_drain got %b want 0", oax.tvalid);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int vk = 0;
        int ck = 0;
        int cyc = 0;
        logic v_hs, c_hs, stall;
        logic [17:0] held;
        logic [15:0] want;
        apply_reset();
        enable = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({12'hA00 + 12'(k), 4'h1});
            exp_q.push_back({12'hC00 + 12'(k), 4'h2});
        end
        held = '0;
        while (cyc < 60 && exp_q.size() > 0) begin
            stall = (cyc >= 6 && cyc < 11);
            oax.tready = !stall;
            vin.tvalid = (vk < 8); vin.tdata = {12'hA00 + 12'(vk), 4'h7};
            cin.tvalid = (ck < 8); cin.tdata = {12'hC00 + 12'(ck), 4'h9};
            #1;
            if (cyc == 6) begin
                held = {oax.tvalid, oax.tdata, oax.tlast};
                vec_cnt++;
                if (oax.tvalid !== 1'b1) begin
                    err_cnt++; $display("FAIL bp_stall_valid got %b want 1", oax.tvalid);
                end
            end else if (stall) begin
                vec_cnt++;
                if ({oax.tvalid, oax.tdata, oax.tlast} !== held) begin
                    err_cnt++; $display("FAIL bp_hold%0d got %h want %h", cyc, {oax.tvalid, oax.tdata, oax.tlast}, held);
                end
            end
            if (stall) begin
                vec_cnt++;
                if ({vin.tready, cin.tready} !== 2'b00) begin
                    err_cnt++; $display("FAIL bp_ready%0d got %b want 00", cyc, {vin.tready, cin.tready});
                end
            end
            v_hs = vin.tvalid && vin.tready;
            c_hs = cin.tvalid && cin.tready;
            if (oax.tvalid && oax.tready) begin
                want = exp_q.pop_front();
                vec_cnt++;
                if (oax.tdata !== want) begin
                    err_cnt++; $display("FAIL bp_word got %h want %h", oax.tdata, want);
                end
            end
            tick();
            if (v_hs) vk++;
            if (c_hs) ck++;
            cyc++;
        end
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++; $display("FAIL bp_timeout got %0d words left want 0", exp_q.size());
        end
        vec_cnt++;
        if (oax.tvalid !== 1'b0) begin
            err_cnt++; $display("FAIL bp_extra_word got %b want 0", oax.tvalid);
        end
        idle_inputs();
    endtask

    task automatic test_short_frame();
        logic [11:0] s;
        apply_reset();
        enable = 1'b1;
        oax4.tready = 1;
        vin4.tvalid = 1;
        for (int k = 0; k < 12; k++) begin
            s = 12'h300 + 12'(k);
            vin4.tdata = {s, 4'h0};
            tick();
            vec_cnt++;
            if ({oax4.tvalid, oax4.tdata, oax4.tlast} !== {1'b1, s, 4'h1, (k % 4) == 3}) begin
                err_cnt++; $display("FAIL short_word%0d got %h want %h", k, {oax4.tvalid, oax4.tdata, oax4.tlast}, {1'b1, s, 4'h1, (k % 4) == 3});
            end
        end
        idle_inputs();
    endtask

    task automatic test_enable_drop();
        logic [17:0] exp;
        apply_reset();
        enable = 1'b1;
        vin.tdata = 16'hABC0; cin.tdata = 16'h1230;
        vin.tvalid = 1; cin.tvalid = 1; oax.tready = 1;
        for (int k = 0; k < 5; k++) tick();
        oax.tready = 0;
        enable = 1'b0;
        #1;
        vec_cnt++;
        if ({vin.tready, cin.tready, word_cnt, last_grant} !== {2'b00, 6'd5, 1'b0}) begin
            err_cnt++; $display("FAIL en_drop_state got %h want %h", {vin.tready, cin.tready, word_cnt, last_grant}, {2'b00, 6'd5, 1'b0});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            vec_cnt++;
            if ({oax.tvalid, oax.tdata, oax.tlast} !== {1'b1, 16'hABC1, 1'b0}) begin
                err_cnt++; $display("FAIL en_hold%0d got %h want %h", k, {oax.tvalid, oax.tdata, oax.tlast}, {1'b1, 16'hABC1, 1'b0});
            end
        end
        oax.tready = 1;
        tick();
        vec_cnt++;
        if (oax.tvalid !== 1'b0) begin
            err_cnt++; $display("FAIL en_drain got %b want 0", oax.tvalid);
        end
        tick();
        vec_cnt++;
        if ({word_cnt, last_grant} !== {6'd0, 1'b1}) begin
            err_cnt++; $display("FAIL en_clear got %h want %h", {word_cnt, last_grant}, {6'd0, 1'b1});
        end
        enable = 1'b1;
        #1;
        vec_cnt++;
        if ({vin.tready, cin.tready} !== 2'b10) begin
            err_cnt++; $display("FAIL en_regrant got %b want 10", {vin.tready, cin.tready});
        end
        for (int k = 0; k < 64; k++) begin
            tick();
            exp = {1'b1, ((k % 2) == 0) ? 16'hABC1 : 16'h1232, k == 63};
            vec_cnt++;
            if ({oax.tvalid, oax.tdata, oax.tlast} !== exp) begin
                err_cnt++; $display("FAIL en_word%0d got %h want %h", k, {oax.tvalid, oax.tdata, oax.tlast}, exp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        enable = 1'b1;
        vin.tdata = 16'h5A50;
        vin.tvalid = 1;
        oax.tready = 0;
        tick();
        vec_cnt++;
        if ({oax.tvalid, oax.tdata, word_cnt, last_grant} !== {1'b1, 16'h5A51, 6'd1, 1'b0}) begin
            err_cnt++; $display("FAIL arst_pre got %h want %h", {oax.tvalid, oax.tdata, word_cnt, last_grant}, {1'b1, 16'h5A51, 6'd1, 1'b0});
        end
        #2 rst = 1'b1;
        #1;
        vec_cnt++;
        if ({oax.tvalid, oax.tdata, oax.tlast} !== 18'h0) begin
            err_cnt++; $display("FAIL arst_out got %h want %h", {oax.tvalid, oax.tdata, oax.tlast}, 18'h0);
        end
        vec_cnt++;
        if ({word_cnt, last_grant, vin.tready, cin.tready} !== {6'd0, 1'b1, 2'b00}) begin
            err_cnt++; $display("FAIL arst_state got %h want %h", {word_cnt, last_grant, vin.tready, cin.tready}, {6'd0, 1'b1, 2'b00});
        end
        tick();
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        vin.tlast = 0; vin.tkeep = '1; vin.tid = 0; vin.tdest = 0; vin.tuser = 0;
        cin.tlast = 0; cin.tkeep = '1; cin.tid = 0; cin.tdest = 0; cin.tuser = 0;
        vin4.tlast = 0; vin4.tkeep = '1; vin4.tid = 0; vin4.tdest = 0; vin4.tuser = 0;
        cin4.tlast = 0; cin4.tkeep = '1; cin4.tid = 0; cin4.tdest = 0; cin4.tuser = 0;
        test_reset();
        test_alternating();
        test_single_requester();
        test_backpressure();
        test_short_frame();
        test_enable_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
